// File: rtl/cached_ram_wb.sv
// rtl/cached_ram_wb.sv - direct-mapped cached RAM with latency-modelled backing store and hit/miss statistics
module cached_ram_wb #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int LINES       = 4,
  parameter int MEM_LATENCY = 3,
  parameter bit WRITE_BACK  = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  input  logic                   writeEnable,
  output logic                   ready,
  output logic                   respValid,
  output logic [DATA_WIDTH-1:0]  dataOut,
  output logic                   hit,
  output logic [COUNT_WIDTH-1:0] hitCount,
  output logic [COUNT_WIDTH-1:0] missCount
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [MEM_LATENCY-1:0] LAT_LAST = MEM_LATENCY[MEM_LATENCY-1:0] - 1'b1;
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_EVICT, S_FILL, S_WTHRU, S_RESP} state_t;

  state_t                 state;
  logic [MEM_LATENCY-1:0] cnt;

  // Per-line status (reset) and payload (not reset)
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_W-1:0]      tags [LINES];
  logic [DATA_WIDTH-1:0] line [LINES];
  logic [DATA_WIDTH-1:0] mem  [DEPTH];

  // Request captured on acceptance, used by the multi-cycle states
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_we;
  logic                  a_hit;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tg;
  logic             lookup_hit;
  logic             victim_dirty;
  logic             accept;
  logic             last;

  assign idx          = addr[IDX_W-1:0];
  assign tg           = addr[ADDR_WIDTH-1:IDX_W];
  assign a_idx        = a_addr[IDX_W-1:0];
  assign a_tg         = a_addr[ADDR_WIDTH-1:IDX_W];
  assign lookup_hit   = valid[idx] && (tags[idx] == tg);
  assign victim_dirty = WRITE_BACK && valid[idx] && dirty[idx];
  assign ready        = (state == S_IDLE);
  assign accept       = req && ready;
  assign last         = (cnt == LAT_LAST);

  // Control FSM: sequencing, line status bits, response outputs and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      valid     <= '0;
      dirty     <= '0;
      respValid <= 1'b0;
      hit       <= 1'b0;
      dataOut   <= '0;
      hitCount  <= '0;
      missCount <= '0;
      a_addr    <= '0;
      a_data    <= '0;
      a_we      <= 1'b0;
      a_hit     <= 1'b0;
    end else begin
      respValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_addr <= addr;
            a_data <= dataIn;
            a_we   <= writeEnable;
            a_hit  <= lookup_hit;
            cnt    <= '0;
            if (lookup_hit) begin
              if (hitCount != CMAX) hitCount <= hitCount + 1'b1;
            end else if (missCount != CMAX) begin
              missCount <= missCount + 1'b1;
            end
            if (!writeEnable) begin
              if (lookup_hit) begin
                respValid <= 1'b1;
                hit       <= 1'b1;
                dataOut   <= line[idx];
              end else if (victim_dirty) begin
                state <= S_EVICT;
              end else begin
                state <= S_FILL;
              end
            end else if (WRITE_BACK) begin
              if (victim_dirty && !lookup_hit) begin
                state <= S_EVICT;
              end else begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b1;
                respValid  <= 1'b1;
                hit        <= lookup_hit;
              end
            end else begin
              state <= S_WTHRU;
            end
          end
        end
        S_EVICT: begin
          if (last) begin
            cnt <= '0;
            if (a_we) begin
              valid[a_idx] <= 1'b1;
              dirty[a_idx] <= 1'b1;
              respValid    <= 1'b1;
              hit          <= a_hit;
              state        <= S_RESP;
            end else begin
              state <= S_FILL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (last) begin
            valid[a_idx] <= 1'b1;
            dirty[a_idx] <= 1'b0;
            respValid    <= 1'b1;
            hit          <= a_hit;
            dataOut      <= mem[a_addr];
            state        <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WTHRU: begin
          if (last) begin
            respValid <= 1'b1;
            hit       <= a_hit;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload storage: line tags/data and the backing store, never reset
  always_ff @(posedge clk) begin
    if (accept && writeEnable && (lookup_hit || (WRITE_BACK && !victim_dirty))) begin
      tags[idx] <= tg;
      line[idx] <= dataIn;
    end
    case (state)
      S_EVICT: begin
        if (last) begin
          mem[{tags[a_idx], a_idx}] <= line[a_idx];
          if (a_we) begin
            tags[a_idx] <= a_tg;
            line[a_idx] <= a_data;
          end
        end
      end
      S_FILL: begin
        if (last) begin
          tags[a_idx] <= a_tg;
          line[a_idx] <= mem[a_addr];
        end
      end
      S_WTHRU: begin
        if (last) mem[a_addr] <= a_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cached_ram_wb.sv
// tb/tb_cached_ram_wb.sv - randomized self-checking bench for cached_ram_wb against a transaction-level model
module tb_cached_ram_wb;
  localparam int L  = 3;
  localparam int LN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       req  [2];
  logic [7:0] addr [2];
  logic [7:0] din  [2];
  logic       we   [2];
  logic       rdy  [2];
  logic       rv   [2];
  logic       ht   [2];
  logic [7:0] dout [2];
  logic [15:0] hc0, mc0;
  logic [3:0]  hc1, mc1;

  // instance 0: write-back, 16-bit counters; instance 1: write-through, 4-bit counters
  cached_ram_wb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LINES(4), .MEM_LATENCY(3),
                  .WRITE_BACK(1'b1), .COUNT_WIDTH(16)) dut_wb (
    .clk(clk), .reset(rst[0]), .req(req[0]), .addr(addr[0]), .dataIn(din[0]),
    .writeEnable(we[0]), .ready(rdy[0]), .respValid(rv[0]), .dataOut(dout[0]),
    .hit(ht[0]), .hitCount(hc0), .missCount(mc0));

  cached_ram_wb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LINES(4), .MEM_LATENCY(3),
                  .WRITE_BACK(1'b0), .COUNT_WIDTH(4)) dut_wt (
    .clk(clk), .reset(rst[1]), .req(req[1]), .addr(addr[1]), .dataIn(din[1]),
    .writeEnable(we[1]), .ready(rdy[1]), .respValid(rv[1]), .dataOut(dout[1]),
    .hit(ht[1]), .hitCount(hc1), .missCount(mc1));

  int nvec = 0;
  int nerr = 0;

  // reference model: per-instance cache lines, backing store and statistics
  bit         m_valid [2][LN];
  bit         m_dirty [2][LN];
  int         m_tag   [2][LN];
  logic [7:0] m_data  [2][LN];
  bit         m_lk    [2][LN];
  logic [7:0] m_mem   [2][256];
  bit         m_mk    [2][256];
  int         m_hc    [2];
  int         m_mc    [2];
  logic [7:0] m_q     [2];
  bit         m_qk    [2];

  function automatic int get_hc(input int u);
    return (u == 0) ? int'(hc0) : int'(hc1);
  endfunction

  function automatic int get_mc(input int u);
    return (u == 0) ? int'(mc0) : int'(mc1);
  endfunction

  task automatic model_reset(input int u);
    for (int i = 0; i < LN; i++) begin
      m_valid[u][i] = 1'b0;
      m_dirty[u][i] = 1'b0;
    end
    m_hc[u] = 0;
    m_mc[u] = 0;
    m_q[u]  = 8'h00;
    m_qk[u] = 1'b1;
  endtask

  task automatic model_op(input int u, input bit w, input int a, input int d,
                          output bit e_hit, output int e_lat, output logic [7:0] e_q, output bit e_qk);
    int  ix, tg, cmax;
    bit  h, vd, wb;
    ix   = a % LN;
    tg   = a / LN;
    wb   = (u == 0);
    cmax = (u == 0) ? 65535 : 15;
    h    = m_valid[u][ix] && (m_tag[u][ix] == tg);
    vd   = wb && m_valid[u][ix] && m_dirty[u][ix];
    e_hit = h;
    if (h) m_hc[u] = (m_hc[u] < cmax) ? m_hc[u] + 1 : cmax;
    else   m_mc[u] = (m_mc[u] < cmax) ? m_mc[u] + 1 : cmax;
    if (vd && !h) begin
      m_mem[u][m_tag[u][ix] * LN + ix] = m_data[u][ix];
      m_mk[u][m_tag[u][ix] * LN + ix]  = m_lk[u][ix];
    end
    if (!w) begin
      if (h) e_lat = 1;
      else begin
        e_lat = vd ? 2 * L + 1 : L + 1;
        m_valid[u][ix] = 1'b1;
        m_dirty[u][ix] = 1'b0;
        m_tag[u][ix]   = tg;
        m_data[u][ix]  = m_mem[u][a];
        m_lk[u][ix]    = m_mk[u][a];
      end
      m_q[u]  = m_data[u][ix];
      m_qk[u] = m_lk[u][ix];
      e_q  = m_q[u];
      e_qk = m_qk[u];
    end else begin
      e_q  = m_q[u];
      e_qk = m_qk[u];
      if (wb) begin
        e_lat = (vd && !h) ? L + 1 : 1;
        m_valid[u][ix] = 1'b1;
        m_dirty[u][ix] = 1'b1;
        m_tag[u][ix]   = tg;
        m_data[u][ix]  = 8'(d);
        m_lk[u][ix]    = 1'b1;
      end else begin
        e_lat = L + 1;
        m_mem[u][a] = 8'(d);
        m_mk[u][a]  = 1'b1;
        if (h) m_data[u][ix] = 8'(d);
      end
    end
  endtask

  // drive one request starting at a falling edge; returns the response cycle (-1 on timeout)
  task automatic do_op(input int u, input bit w, input int a, input int d,
                       output int lat, output bit h, output logic [7:0] q, output int busy);
    for (int n = 0; n < 20 && !rdy[u]; n++) @(negedge clk);
    req[u]  = 1'b1;
    we[u]   = w;
    addr[u] = 8'(a);
    din[u]  = 8'(d);
    @(posedge clk);
    #1 req[u] = 1'b0;
    lat  = -1;
    h    = 1'b0;
    q    = 8'h00;
    busy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rv[u]) begin
        lat = n;
        h   = ht[u];
        q   = dout[u];
        break;
      end
      if (!rdy[u]) busy++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      nvec++; if (rdy[u] !== 1'b1) begin nerr++; $display("FAIL reset_ready u%0d: got %b want 1", u, rdy[u]); end
      nvec++; if (rv[u] !== 1'b0) begin nerr++; $display("FAIL reset_respvalid u%0d: got %b want 0", u, rv[u]); end
      nvec++; if (ht[u] !== 1'b0) begin nerr++; $display("FAIL reset_hit u%0d: got %b want 0", u, ht[u]); end
      nvec++; if (dout[u] !== 8'h00) begin nerr++; $display("FAIL reset_dataout u%0d: got %h want 00", u, dout[u]); end
      nvec++; if (get_hc(u) !== 0) begin nerr++; $display("FAIL reset_hitcount u%0d: got %0d want 0", u, get_hc(u)); end
      nvec++; if (get_mc(u) !== 0) begin nerr++; $display("FAIL reset_misscount u%0d: got %0d want 0", u, get_mc(u)); end
    end
  endtask

  task automatic test_write_read();
    int lat, busy, el; bit h, eh, eqk; logic [7:0] q, eq;
    model_op(0, 1'b1, 4, 8'hFF, eh, el, eq, eqk);
    do_op(0, 1'b1, 4, 8'hFF, lat, h, q, busy);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL wr_fast_latency: got %0d want 1", lat); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL wr_fast_hit: got %b want 0", h); end
    model_op(0, 1'b0, 4, 0, eh, el, eq, eqk);
    do_op(0, 1'b0, 4, 0, lat, h, q, busy);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL rd_hit_latency: got %0d want 1", lat); end
    nvec++; if (h !== 1'b1) begin nerr++; $display("FAIL rd_hit_hit: got %b want 1", h); end
    nvec++; if (q !== 8'hFF) begin nerr++; $display("FAIL rd_hit_data: got %h want ff", q); end
    nvec++; if (hc0 !== 16'd1) begin nerr++; $display("FAIL wr_rd_hitcount: got %0d want 1", hc0); end
    nvec++; if (mc0 !== 16'd1) begin nerr++; $display("FAIL wr_rd_misscount: got %0d want 1", mc0); end
  endtask

  task automatic test_dirty_evict();
    int lat, busy, el; bit h, eh, eqk; logic [7:0] q, eq;
    model_op(0, 1'b1, 4, 8'hAA, eh, el, eq, eqk);
    do_op(0, 1'b1, 4, 8'hAA, lat, h, q, busy);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL evict_wr1_latency: got %0d want 1", lat); end
    model_op(0, 1'b1, 8, 8'h55, eh, el, eq, eqk);
    do_op(0, 1'b1, 8, 8'h55, lat, h, q, busy);
    nvec++; if (lat !== L + 1) begin nerr++; $display("FAIL evict_wr2_latency: got %0d want %0d", lat, L + 1); end
    nvec++; if (busy !== L) begin nerr++; $display("FAIL evict_wr2_busy: got %0d want %0d", busy, L); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL evict_wr2_hit: got %b want 0", h); end
    nvec++; if (q !== 8'hFF) begin nerr++; $display("FAIL evict_wr2_dataout_held: got %h want ff", q); end
    model_op(0, 1'b0, 4, 0, eh, el, eq, eqk);
    do_op(0, 1'b0, 4, 0, lat, h, q, busy);
    nvec++; if (lat !== 2 * L + 1) begin nerr++; $display("FAIL evict_rd_latency: got %0d want %0d", lat, 2 * L + 1); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL evict_rd_hit: got %b want 0", h); end
    nvec++; if (q !== 8'hAA) begin nerr++; $display("FAIL evict_rd_data: got %h want aa", q); end
  endtask

  task automatic test_write_through();
    int lat, busy, el; bit h, eh, eqk; logic [7:0] q, eq;
    model_op(1, 1'b1, 12, 8'h33, eh, el, eq, eqk);
    do_op(1, 1'b1, 12, 8'h33, lat, h, q, busy);
    nvec++; if (lat !== L + 1) begin nerr++; $display("FAIL wt_wr1_latency: got %0d want %0d", lat, L + 1); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL wt_wr1_hit: got %b want 0", h); end
    model_op(1, 1'b0, 12, 0, eh, el, eq, eqk);
    do_op(1, 1'b0, 12, 0, lat, h, q, busy);
    nvec++; if (lat !== L + 1) begin nerr++; $display("FAIL wt_rd1_latency: got %0d want %0d", lat, L + 1); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL wt_rd1_hit: got %b want 0", h); end
    nvec++; if (q !== 8'h33) begin nerr++; $display("FAIL wt_rd1_data: got %h want 33", q); end
    model_op(1, 1'b1, 12, 8'h44, eh, el, eq, eqk);
    do_op(1, 1'b1, 12, 8'h44, lat, h, q, busy);
    nvec++; if (h !== 1'b1) begin nerr++; $display("FAIL wt_wr2_hit: got %b want 1", h); end
    nvec++; if (busy !== L) begin nerr++; $display("FAIL wt_wr2_busy: got %0d want %0d", busy, L); end
    model_op(1, 1'b0, 12, 0, eh, el, eq, eqk);
    do_op(1, 1'b0, 12, 0, lat, h, q, busy);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL wt_rd2_latency: got %0d want 1", lat); end
    nvec++; if (h !== 1'b1) begin nerr++; $display("FAIL wt_rd2_hit: got %b want 1", h); end
    nvec++; if (q !== 8'h44) begin nerr++; $display("FAIL wt_rd2_data: got %h want 44", q); end
  endtask

  task automatic test_back_to_back();
    int lat, busy; bit h; logic [7:0] q;
    bit eh [4]; int el [4]; logic [7:0] eq [4]; bit eqk [4];
    for (int i = 0; i < 4; i++) begin
      model_op(0, 1'b1, i, 8'h10 + 8'(i * 17), eh[i], el[i], eq[i], eqk[i]);
      do_op(0, 1'b1, i, 8'h10 + 8'(i * 17), lat, h, q, busy);
    end
    for (int i = 0; i < 4; i++) model_op(0, 1'b0, i, 0, eh[i], el[i], eq[i], eqk[i]);
    for (int n = 0; n < 20 && !rdy[0]; n++) @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) addr[0] = 8'(i + 1);
      else req[0] = 1'b0;
      @(negedge clk);
      nvec++; if (rv[0] !== 1'b1) begin nerr++; $display("FAIL b2b_respvalid[%0d]: got %b want 1", i, rv[0]); end
      nvec++; if (rdy[0] !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, rdy[0]); end
      nvec++; if (ht[0] !== eh[i]) begin nerr++; $display("FAIL b2b_hit[%0d]: got %b want %b", i, ht[0], eh[i]); end
      nvec++; if (dout[0] !== eq[i]) begin nerr++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dout[0], eq[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, busy, el; bit h, eh, eqk; logic [7:0] q, eq;
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    model_reset(0);
    @(negedge clk);
    model_op(0, 1'b1, 4, 8'h11, eh, el, eq, eqk);
    do_op(0, 1'b1, 4, 8'h11, lat, h, q, busy);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL abort_wr_latency: got %0d want 1", lat); end
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd5;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1;
    nvec++; if (rdy[0] !== 1'b1) begin nerr++; $display("FAIL abort_ready: got %b want 1", rdy[0]); end
    nvec++; if (rv[0] !== 1'b0) begin nerr++; $display("FAIL abort_respvalid: got %b want 0", rv[0]); end
    nvec++; if (hc0 !== 16'd0) begin nerr++; $display("FAIL abort_hitcount: got %0d want 0", hc0); end
    nvec++; if (mc0 !== 16'd0) begin nerr++; $display("FAIL abort_misscount: got %0d want 0", mc0); end
    model_reset(0);
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    model_op(0, 1'b0, 4, 0, eh, el, eq, eqk);
    do_op(0, 1'b0, 4, 0, lat, h, q, busy);
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL abort_rd_hit: got %b want 0", h); end
    nvec++; if (lat !== el) begin nerr++; $display("FAIL abort_rd_latency: got %0d want %0d", lat, el); end
    if (eqk) begin
      nvec++; if (q !== eq) begin nerr++; $display("FAIL abort_rd_data: got %h want %h", q, eq); end
    end
  endtask

  task automatic test_saturation();
    int lat, busy, el; bit h, eh, eqk; logic [7:0] q, eq;
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    model_reset(1);
    @(negedge clk);
    model_op(1, 1'b1, 20, 8'h5A, eh, el, eq, eqk);
    do_op(1, 1'b1, 20, 8'h5A, lat, h, q, busy);
    model_op(1, 1'b0, 20, 0, eh, el, eq, eqk);
    do_op(1, 1'b0, 20, 0, lat, h, q, busy);
    for (int i = 0; i < 20; i++) begin
      model_op(1, 1'b0, 20, 0, eh, el, eq, eqk);
      do_op(1, 1'b0, 20, 0, lat, h, q, busy);
      nvec++; if (h !== 1'b1 || q !== 8'h5A) begin nerr++; $display("FAIL sat_rd[%0d]: got hit=%b data=%h want hit=1 data=5a", i, h, q); end
    end
    nvec++; if (hc1 !== 4'd15) begin nerr++; $display("FAIL sat_hitcount: got %0d want 15", hc1); end
    nvec++; if (mc1 !== 4'd2) begin nerr++; $display("FAIL sat_misscount: got %0d want 2", mc1); end
  endtask

  task automatic test_random();
    int lat, busy, el, a, d; bit h, eh, eqk, w; logic [7:0] q, eq;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 80; i++) begin
        a = int'($urandom_range(0, 31));
        d = int'($urandom_range(0, 255));
        w = 1'($urandom_range(0, 1));
        model_op(u, w, a, d, eh, el, eq, eqk);
        do_op(u, w, a, d, lat, h, q, busy);
        nvec++; if (lat !== el) begin nerr++; $display("FAIL rnd_latency u%0d #%0d a=%0d w=%b: got %0d want %0d", u, i, a, w, lat, el); end
        nvec++; if (h !== eh) begin nerr++; $display("FAIL rnd_hit u%0d #%0d a=%0d w=%b: got %b want %b", u, i, a, w, h, eh); end
        if (eqk) begin
          nvec++; if (q !== eq) begin nerr++; $display("FAIL rnd_data u%0d #%0d a=%0d w=%b: got %h want %h", u, i, a, w, q, eq); end
        end
      end
      nvec++; if (get_hc(u) !== m_hc[u]) begin nerr++; $display("FAIL rnd_hitcount u%0d: got %0d want %0d", u, get_hc(u), m_hc[u]); end
      nvec++; if (get_mc(u) !== m_mc[u]) begin nerr++; $display("FAIL rnd_misscount u%0d: got %0d want %0d", u, get_mc(u), m_mc[u]); end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]  = 1'b1;
      req[u]  = 1'b0;
      addr[u] = 8'h00;
      din[u]  = 8'h00;
      we[u]   = 1'b0;
      model_reset(u);
      for (int k = 0; k < 256; k++) m_mk[u][k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_dirty_evict();
    test_write_through();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
